// File: rtl/avalon_pio_key_poller_if.sv
// Avalon-MM read-only master/slave bundle for the PIO key poller.
// Address, read strobe, stall and 32-bit read data.
interface avalon_pio_key_poller_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/avalon_pio_key_poller.sv
// Polls a PIO data register, debounces it and queues key change events.
// Define KEY_POLLER_IRQ_EN to add the registered irq output.
module avalon_pio_key_poller #(
  parameter int WIDTH            = 2,
  parameter int POLL_DIV         = 50000,
  parameter int READ_LATENCY     = 1,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int ACTIVE_LOW       = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  avalon_pio_key_poller_if.master avm,
  output logic [WIDTH-1:0]       keys_stable,
  output logic [WIDTH-1:0]       press_pulse,
  output logic [WIDTH-1:0]       release_pulse,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [WIDTH-1:0]       evt_data,
  output logic                   overflow,
  input  logic                   overflow_clr
`ifdef KEY_POLLER_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam int DW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [3:0] CMAX = 4'(DEBOUNCE_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t           state;
  logic [DW-1:0]    div;
  logic [1:0]       lat;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] last_sample;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic             cap;
  logic             same;
  logic             upd;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             full;
  logic             pop;
  logic             drop;

  assign avm.avm_address = 2'd0;

  generate
    if (WIDTH < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^avm.avm_readdata[31:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      div          <= DW'(POLL_DIV - 1);
      lat          <= 2'd0;
      avm.avm_read <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (div == '0) begin
            state        <= REQ;
            avm.avm_read <= 1'b1;
          end else begin
            div <= div - DW'(1);
          end
        end
        REQ: begin
          if (!avm.avm_waitrequest) begin
            state        <= WAIT;
            avm.avm_read <= 1'b0;
            lat          <= 2'(READ_LATENCY - 1);
          end
        end
        WAIT: begin
          if (lat == 2'd0) begin
            state <= IDLE;
            div   <= DW'(POLL_DIV - 1);
          end else begin
            lat <= lat - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cap    = (state == WAIT) && (lat == 2'd0);
  assign raw    = avm.avm_readdata[WIDTH-1:0];
  assign sample = (ACTIVE_LOW != 0) ? ~raw : raw;
  assign same   = (sample == last_sample);

  // The run count includes the current sample, so N equal samples settle.
  assign cnt_nxt = (cnt == CMAX) ? cnt : cnt + 4'd1;
  assign upd     = cap && same && (cnt_nxt == CMAX)
                && (last_sample != keys_stable);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_sample   <= '0;
      cnt           <= 4'd0;
      keys_stable   <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      press_pulse   <= '0;
      release_pulse <= '0;
      if (cap) begin
        if (!same) begin
          last_sample <= sample;
          cnt         <= 4'd0;
        end else begin
          cnt <= cnt_nxt;
        end
      end
      if (upd) begin
        keys_stable   <= last_sample;
        press_pulse   <= last_sample & ~keys_stable;
        release_pulse <= ~last_sample & keys_stable;
      end
    end
  end

  assign evt_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW])
                  && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = evt_valid && evt_ready;
  assign drop      = upd && full && !pop;
  assign evt_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (upd && !drop) begin
        mem[wr_ptr[AW-1:0]] <= last_sample;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef KEY_POLLER_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= evt_valid | overflow;
    end
  end
`endif

endmodule

// File: tb/tb_avalon_pio_key_poller.sv
// Bench for avalon_pio_key_poller: directed phases plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_avalon_pio_key_poller;

  localparam int W  = 2;
  localparam int PD = 4;
  localparam int RL = 1;
  localparam int DB = 4;
  localparam int AL = 1;
  localparam int FD = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] keys_stable;
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;
  logic         evt_valid;
  logic         evt_ready;
  logic [W-1:0] evt_data;
  logic         overflow;
  logic         overflow_clr;
`ifdef KEY_POLLER_IRQ_EN
  logic         irq;
`endif

  avalon_pio_key_poller_if bus ();

  avalon_pio_key_poller #(
    .WIDTH(W), .POLL_DIV(PD), .READ_LATENCY(RL),
    .DEBOUNCE_SAMPLES(DB), .ACTIVE_LOW(AL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avm(bus),
    .keys_stable(keys_stable),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data(evt_data),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
`ifdef KEY_POLLER_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int press_seen = 0;
  bit chk_en = 0;
  logic [W-1:0] key_raw;

  // Reference model: absolute edge times for the poll schedule,
  // run length for debounce, a queue for the event FIFO.
  int t, issue_t, cap_t, n_cap, m_run;
  bit m_read, m_ovf, m_irq;
  logic [W-1:0] m_stable, m_press, m_rel, m_last;
  logic [W-1:0] m_q[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = 0;
    issue_t = PD;
    cap_t = -1;
    n_cap = 0;
    m_run = 1;
    m_read = 0;
    m_ovf = 0;
    m_irq = 0;
    m_stable = '0;
    m_press = '0;
    m_rel = '0;
    m_last = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit pop, push, drop, old_v, old_o;
    logic [W-1:0] s;
    old_v = (m_q.size() > 0);
    old_o = m_ovf;
    t++;
    push = 0;
    m_press = '0;
    m_rel = '0;
    pop = old_v && evt_ready;
    if (!m_read && cap_t < 0 && t == issue_t) begin
      m_read = 1;
    end else if (m_read && !bus.avm_waitrequest) begin
      m_read = 0;
      cap_t = t + RL;
    end else if (cap_t >= 0 && t == cap_t) begin
      cap_t = -1;
      issue_t = t + PD;
      n_cap++;
      s = bus.avm_readdata[W-1:0];
      if (AL != 0) s = ~s;
      if (s != m_last) begin
        m_last = s;
        m_run = 1;
      end else begin
        if (m_run < 100) m_run++;
        if (m_run >= DB && m_last != m_stable) begin
          m_press = m_last & ~m_stable;
          m_rel = ~m_last & m_stable;
          m_stable = m_last;
          push = 1;
        end
      end
    end
    drop = push && (m_q.size() == FD) && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !drop) m_q.push_back(m_stable);
    if (drop) m_ovf = 1;
    else if (overflow_clr) m_ovf = 0;
    m_irq = old_v | old_o;
  endtask

  // Valid key data only in the cycle the model expects the capture.
  task automatic drive_rd();
    logic [31:0] r;
    r = $urandom;
    if (cap_t == t + 1) r[W-1:0] = key_raw;
    bus.avm_readdata = r;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    drive_rd();
  endtask

  task automatic wait_caps(int n);
    int target;
    target = n_cap + n;
    for (int i = 0; i < 100 * n && n_cap < target; i++) tick();
    if (n_cap < target) chk("capture_timeout", 0, 1);
  endtask

  task automatic hold_raw(logic [W-1:0] v, int n);
    key_raw = v;
    drive_rd();
    wait_caps(n);
  endtask

  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      chk("avm_read", bus.avm_read, m_read);
      chk("avm_address", bus.avm_address, 0);
      chk("keys_stable", keys_stable, m_stable);
      chk("press_pulse", press_pulse, m_press);
      chk("release_pulse", release_pulse, m_rel);
      chk("evt_valid", evt_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("evt_data", evt_data, m_q[0]);
      chk("overflow", overflow, m_ovf);
`ifdef KEY_POLLER_IRQ_EN
      chk("irq", irq, m_irq);
`endif
      if (press_pulse != 0) press_seen++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [W-1:0] pat [9];
  int hold_cnt, base;

  initial begin
    pat = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11,
            2'b10, 2'b10, 2'b10, 2'b10};
    reset_n = 1'b0;
    key_raw = 2'b10;
    evt_ready = 1'b0;
    overflow_clr = 1'b0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata = '1;
    model_reset();
    #1;
    chk("rst_read", bus.avm_read, 0);
    chk("rst_evt_valid", evt_valid, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    chk_en = 1;

    // First read 4 edges after release; 4th capture settles the key.
    while (t < 3) tick();
    chk("lit_read_t3", bus.avm_read, 0);
    tick();
    chk("lit_read_t4", bus.avm_read, 1);
    while (t < 23) tick();
    chk("lit_stable_t23", keys_stable, 2'b00);
    tick();
    chk("lit_stable_t24", keys_stable, 2'b01);
    chk("lit_press_t24", press_pulse, 2'b01);
    chk("lit_evt_t24", evt_data, 2'b01);
    chk("lit_valid_t24", evt_valid, 1);

    // Release, then the bounce pattern gives exactly one press.
    evt_ready = 1'b1;
    hold_raw(2'b11, 4);
    base = press_seen;
    for (int i = 0; i < 9; i++) hold_raw(pat[i], 1);
    tick();
    chk("lit_bounce_events", press_seen - base, 1);
    chk("lit_bounce_stable", keys_stable, 2'b01);

    // Stall the read for 3 cycles.
    for (int i = 0; i < 50 && !m_read; i++) tick();
    hold_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.avm_read) hold_cnt++;
      bus.avm_waitrequest = (i < 3);
      tick();
    end
    chk("lit_wr_hold", hold_cnt, 4);
    chk("lit_wr_accept", bus.avm_read, 0);

    // Three changes into a 2-deep FIFO with no consumer.
    evt_ready = 1'b0;
    hold_raw(2'b11, 4);
    hold_raw(2'b10, 4);
    hold_raw(2'b11, 4);
    tick();
    chk("lit_ovf_set", overflow, 1);
    chk("lit_ovf_head", evt_data, 2'b00);
    evt_ready = 1'b1;
    tick();
    chk("lit_pop2_valid", evt_valid, 1);
    chk("lit_pop2_data", evt_data, 2'b01);
    tick();
    chk("lit_pop_empty", evt_valid, 0);
    evt_ready = 1'b0;
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("lit_ovf_clr", overflow, 0);

    // Reset while a read response is pending.
    hold_raw(2'b10, 4);
    for (int i = 0; i < 50 && !(cap_t >= 0 && !m_read); i++)
      tick();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("lit_rst_read", bus.avm_read, 0);
    chk("lit_rst_stable", keys_stable, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (3) tick();
    chk("lit_stale_valid", evt_valid, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.avm_waitrequest = ($urandom_range(3) == 0);
      evt_ready = $urandom_range(1) == 1;
      overflow_clr = ($urandom_range(15) == 0);
      if ($urandom_range(59) == 0) key_raw = W'($urandom);
      drive_rd();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
